// File: rtl/cnt_bcd_n.sv
// cnt_bcd_n: multi-digit packed-BCD up/down counter with parallel load, wrap/saturate and cascade strobe
module cnt_bcd_n #(
  parameter int DIGITS = 2,
  parameter int WRAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              up,
  input  logic [4*DIGITS-1:0] data,
  output logic [4*DIGITS-1:0] dout,
  output logic              cout,
  output logic              lderr
);
  localparam int W = 4 * DIGITS;
  logic [DIGITS:0] lo9, lo0;
  logic [DIGITS-1:0] is9, is0, bad;
  logic [W-1:0] step, ld;
  logic term, hold;
  assign lo9[0] = 1'b1;
  assign lo0[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] q, v;
    assign q = dout[4*d+:4];
    assign v = data[4*d+:4];
    assign is9[d] = q == 4'd9;
    assign is0[d] = q == 4'd0;
    assign lo9[d+1] = lo9[d] & is9[d];
    assign lo0[d+1] = lo0[d] & is0[d];
    assign bad[d] = v > 4'd9;
    assign ld[4*d+:4] = bad[d] ? 4'd0 : v;
    assign step[4*d+:4] = up ? (lo9[d] ? (is9[d] ? 4'd0 : q + 4'd1) : q)
                             : (lo0[d] ? (is0[d] ? 4'd9 : q - 4'd1) : q);
  end
  assign term = up ? lo9[DIGITS] : lo0[DIGITS];
  assign hold = term && (WRAP == 0);
  assign cout = en & ~load & term;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout <= '0;
      lderr <= 1'b0;
    end else if (load) begin
      dout <= ld;
      lderr <= |bad;
    end else if (en && !hold) dout <= step;
endmodule
